// File: rtl/button_cmd_encoder.sv
// button_cmd_encoder: synchronises and debounces two push-buttons (arm,
// toggle), detects presses and issues single-cycle command codes on `a`
// for the downstream toggle machine. Toggle presses are only forwarded
// once the encoder has been armed; discarded toggles are counted.
module button_cmd_encoder #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_arm,
   input  logic       btn_toggle,
   output logic [1:0] a,
   output logic       armed,
   output logic [3:0] drop_cnt
);

   // Index 0 carries the arm button, index 1 the toggle button.
   localparam int BTN_ARM    = 0;
   localparam int BTN_TOGGLE = 1;

   // Counter value at which one more mismatching cycle flips the level.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] CMD_IDLE   = 2'b00;
   localparam logic [1:0] CMD_TOGGLE = 2'b01;
   localparam logic [1:0] CMD_ARM    = 2'b10;

   typedef enum logic {
      IDLE,
      ARMED
   } state_t;

   logic [1:0]       raw;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       db;
   logic [1:0]       db_q;
   logic [CNT_W-1:0] cnt [2];
   logic [1:0]       press;

   state_t           state;
   state_t           next_state;
   logic [1:0]       a_next;
   logic             drop_inc;

   assign raw = {btn_toggle, btn_arm};

   // Two-flop synchroniser per button; only sync2 is used downstream.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 2'b00;
         sync2 <= 2'b00;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Debounce: the level follows the synchronised input only after it has
   // disagreed for DEBOUNCE_CYCLES consecutive cycles; agreement clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db     <= 2'b00;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               db[i]  <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Delayed copy of the debounced levels for rising-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_q <= 2'b00;
      end else begin
         db_q <= db;
      end
   end

   assign press = db & ~db_q;

   // FSM state register plus the registered outputs derived from it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         a        <= CMD_IDLE;
         armed    <= 1'b0;
         drop_cnt <= 4'd0;
      end else begin
         state <= next_state;
         a     <= a_next;
         armed <= (next_state == ARMED);
         if (drop_inc && (drop_cnt != 4'd15)) begin
            drop_cnt <= drop_cnt + 4'd1;
         end
      end
   end

   // Next-state and command decode; an arm press always beats a toggle
   // press in the same cycle, and that toggle is counted as dropped.
   always_comb begin
      next_state = state;
      a_next     = CMD_IDLE;
      drop_inc   = 1'b0;
      if (press[BTN_ARM]) begin
         a_next     = CMD_ARM;
         next_state = ARMED;
         drop_inc   = press[BTN_TOGGLE];
      end else if (press[BTN_TOGGLE]) begin
         if (state == ARMED) begin
            a_next = CMD_TOGGLE;
         end else begin
            drop_inc = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_button_cmd_encoder.sv
// Directed testbench for button_cmd_encoder with the default debounce depth.
module tb_button_cmd_encoder;

   logic       clk;
   logic       reset;
   logic       btn_arm;
   logic       btn_toggle;
   logic [1:0] a;
   logic       armed;
   logic [3:0] drop_cnt;

   int total;
   int bad_cnt;

   int         nz;
   int         first;
   logic [3:0] seen;
   logic       armed_first;
   int         nz_sum;

   button_cmd_encoder #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_arm   (btn_arm),
      .btn_toggle(btn_toggle),
      .a         (a),
      .armed     (armed),
      .drop_cnt  (drop_cnt)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its hand-computed expectation.
   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad_cnt++;
         $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n cycles, sampling 1 ns after each rising edge, and record how
   // many cycles had a non-zero command, the first such cycle (1-based),
   // which codes appeared and the armed flag in the first command cycle.
   task automatic apply_stimulus(input int n, output int nz_o, output int first_o,
                                 output logic [3:0] seen_o, output logic armed_o);
      nz_o    = 0;
      first_o = 0;
      seen_o  = 4'b0000;
      armed_o = 1'b0;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         if (a !== 2'b00) begin
            nz_o++;
            if (first_o == 0) begin
               first_o = i;
               armed_o = armed;
            end
            seen_o[a] = 1'b1;
         end
      end
   endtask

   // One clean toggle press: held 6 cycles, released 6 cycles.
   task automatic toggle_press(output int nz_o);
      int n1;
      int n2;
      int f;
      logic [3:0] s;
      logic am;
      btn_toggle = 1'b1;
      apply_stimulus(6, n1, f, s, am);
      btn_toggle = 1'b0;
      apply_stimulus(6, n2, f, s, am);
      nz_o = n1 + n2;
   endtask

   initial begin
      total      = 0;
      bad_cnt    = 0;
      reset      = 1'b0;
      btn_arm    = 1'b0;
      btn_toggle = 1'b0;

      // Reset held low for three cycles, checked mid-cycle.
      repeat (3) @(posedge clk);
      #2;
      check_output("reset_a", a, 2'b00);
      check_output("reset_armed", armed, 1'b0);
      check_output("reset_drop", drop_cnt, 4'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      apply_stimulus(5, nz, first, seen, armed_first);
      check_output("idle_nz", nz, 0);
      check_output("idle_armed", armed, 1'b0);

      // Arm press held 20 cycles: one 10 pulse, seven edges after sampling.
      $display("[TB] arm latency");
      btn_arm = 1'b1;
      apply_stimulus(20, nz, first, seen, armed_first);
      check_output("arm_nz", nz, 1);
      check_output("arm_first", first, 7);
      check_output("arm_codes", seen, 4'b0100);
      check_output("arm_armed_first", armed_first, 1'b1);
      check_output("arm_armed_end", armed, 1'b1);
      btn_arm = 1'b0;
      apply_stimulus(10, nz, first, seen, armed_first);
      check_output("arm_release_nz", nz, 0);

      // Bounce on toggle while armed: nothing, then a clean hold gives 01.
      $display("[TB] bounce rejection");
      btn_toggle = 1'b1;
      apply_stimulus(3, nz, first, seen, armed_first);
      nz_sum = nz;
      btn_toggle = 1'b0;
      apply_stimulus(2, nz, first, seen, armed_first);
      nz_sum += nz;
      btn_toggle = 1'b1;
      apply_stimulus(3, nz, first, seen, armed_first);
      nz_sum += nz;
      btn_toggle = 1'b0;
      apply_stimulus(8, nz, first, seen, armed_first);
      nz_sum += nz;
      check_output("bounce_nz", nz_sum, 0);
      btn_toggle = 1'b1;
      apply_stimulus(10, nz, first, seen, armed_first);
      check_output("toggle_nz", nz, 1);
      check_output("toggle_first", first, 7);
      check_output("toggle_codes", seen, 4'b0010);
      check_output("toggle_drop", drop_cnt, 4'd0);
      btn_toggle = 1'b0;
      apply_stimulus(10, nz, first, seen, armed_first);

      // Both buttons rise together while armed: arm wins, toggle dropped.
      $display("[TB] simultaneous press");
      btn_arm    = 1'b1;
      btn_toggle = 1'b1;
      apply_stimulus(10, nz, first, seen, armed_first);
      check_output("simul_nz", nz, 1);
      check_output("simul_first", first, 7);
      check_output("simul_codes", seen, 4'b0100);
      check_output("simul_drop", drop_cnt, 4'd1);
      check_output("simul_armed", armed, 1'b1);
      btn_arm    = 1'b0;
      btn_toggle = 1'b0;
      apply_stimulus(10, nz, first, seen, armed_first);

      // Asynchronous reset while the arm pulse is on a.
      $display("[TB] reset during pulse");
      btn_arm = 1'b1;
      apply_stimulus(7, nz, first, seen, armed_first);
      check_output("pulse_present", a, 2'b10);
      #3;
      reset = 1'b0;
      #1;
      check_output("async_a", a, 2'b00);
      check_output("async_armed", armed, 1'b0);
      check_output("async_drop", drop_cnt, 4'd0);
      btn_arm = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      apply_stimulus(12, nz, first, seen, armed_first);
      check_output("post_reset_nz", nz, 0);
      check_output("post_reset_armed", armed, 1'b0);

      // Toggle presses while idle are dropped and counted, saturating at 15.
      $display("[TB] idle toggles");
      nz_sum = 0;
      for (int p = 0; p < 3; p++) begin
         toggle_press(nz);
         nz_sum += nz;
      end
      check_output("idle_toggle_nz", nz_sum, 0);
      check_output("idle_drop3", drop_cnt, 4'd3);
      for (int p = 0; p < 11; p++) begin
         toggle_press(nz);
         nz_sum += nz;
      end
      check_output("idle_drop14", drop_cnt, 4'd14);
      for (int p = 0; p < 9; p++) begin
         toggle_press(nz);
         nz_sum += nz;
      end
      check_output("idle_drop_sat", drop_cnt, 4'd15);
      check_output("idle_toggle_nz_all", nz_sum, 0);
      check_output("idle_toggle_armed", armed, 1'b0);

      // Reset two cycles into an arm debounce; held button re-presses after.
      $display("[TB] reset mid-debounce");
      btn_arm = 1'b1;
      apply_stimulus(2, nz, first, seen, armed_first);
      check_output("middb_pre_nz", nz, 0);
      reset = 1'b0;
      #1;
      check_output("middb_drop", drop_cnt, 4'd0);
      @(posedge clk);
      #1;
      check_output("middb_a", a, 2'b00);
      reset = 1'b1;
      apply_stimulus(12, nz, first, seen, armed_first);
      check_output("middb_nz", nz, 1);
      check_output("middb_first", first, 7);
      check_output("middb_codes", seen, 4'b0100);
      check_output("middb_armed", armed, 1'b1);
      btn_arm = 1'b0;
      apply_stimulus(4, nz, first, seen, armed_first);

      $display("test done: total=%0d bad=%0d", total, bad_cnt);
      $finish;
   end

   // Absolute time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/button_cmd_encoder.md
Name: button_cmd_encoder

Overview:
- Front-end stage that drives the 2-bit command input `a` of the downstream Mealy toggle machine.
- Takes two raw push-buttons, arm and toggle, and synchronises and debounces each one.
- Detects each press and emits a single-cycle command code on `a`.
- Tracks whether the system is armed, so toggle commands are only issued after an arm; also counts dropped toggle presses.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronised input must differ from its debounced level before that level flips. Legal range 1 to 2^CNT_W-1.
- CNT_W, default 3: width of each debounce counter.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_arm  input  1  raw asynchronous arm button, active-high.
- btn_toggle  input  1  raw asynchronous toggle button, active-high.
- a  output  2  command code to the downstream stage: 00 = idle, 01 = toggle, 10 = arm; 11 is never driven.
- armed  output  1  high while the encoder is in ARMED.
- drop_cnt  output  4  saturating count of toggle presses discarded.

Behaviour:
- Reset (reset=0, asynchronous) clears every flop immediately:
  - a=00, armed=0, drop_cnt=0;
  - sync flops=0, debounced levels=0, counters=0;
  - FSM=IDLE.
- Synchroniser: each button passes through two flops; only the second-stage value (s_x) is used after that.
- Debounce, per button, independent:
  - If s_x equals the debounced level db_x, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter would reach DEBOUNCE_CYCLES, db_x takes s_x and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes db_x.
- Press detection: press_x=1 for the one cycle after db_x goes 0 to 1. Releases (1 to 0) produce nothing.
- FSM:
  - IDLE:
    - press_arm → a=10 for one cycle, go to ARMED.
    - press_toggle → a=00, drop_cnt+1.
  - ARMED:
    - press_arm → a=10 for one cycle, stay in ARMED (re-arm; the downstream stage restarts).
    - press_toggle → a=01 for one cycle.
- Simultaneous press_arm and press_toggle in the same cycle: arm wins and a=10. The toggle is counted in drop_cnt in both states.
- `a` is registered. It is 00 in every cycle without a press event and is never held non-zero for two consecutive cycles.
- `armed` is registered and rises in the same cycle a=10 first appears.
- drop_cnt saturates at 15 and never wraps.
- Latency: a raw rising edge held stable and first sampled at clock edge k produces `a` non-zero in the cycle following edge k+DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges after sampling.
- A button held continuously produces exactly one command. The next command needs a release that is debounced low, followed by a new press.
- Reset asserted mid-operation (debounce in progress, or a pulse on `a`): outputs go to reset values immediately and any pending press is discarded.
- After reset deasserts, a button already held high counts as a new press once it is debounced.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, buttons low → a=00, armed=0, drop_cnt=0 throughout, including asynchronously mid-cycle.
- Arm latency (DEBOUNCE_CYCLES=4): btn_arm rises and is held 20 cycles → a=10 for exactly one cycle, 7 edges after first sample; armed=1 from that cycle; no further command while held.
- Bounce rejection: btn_toggle pulses high for 3 cycles, low 2, high 3 while ARMED → a stays 00. Then held high 10 cycles → a=01 once.
- Toggle while IDLE: 3 clean toggle presses before any arm → a=00 always, drop_cnt=3. Then 20 more presses → drop_cnt=15 (saturated).
- Simultaneous: both buttons rise on the same edge in ARMED → a=10 once, never 01; drop_cnt increments by 1.
- Reset mid-debounce: btn_arm held, reset pulsed low 2 cycles after the press began, btn_arm still held → no pulse before reset. After reset deasserts, a=10 follows DEBOUNCE_CYCLES+3 edges later.
